// File: rtl/axis_framer_pkg.sv
// Shared types and constants for the AXI-Stream packet framer.
// Defining AXIS_FRAMER_CSUM_EN adds the trailing XOR checksum byte.
package axis_framer_pkg;

    localparam int HDR_LEN = 4;
    localparam int LEN_W   = 16;

`ifdef AXIS_FRAMER_CSUM_EN
    localparam bit CSUM_ON = 1'b1;
`else
    localparam bit CSUM_ON = 1'b0;
`endif

    typedef enum logic [2:0] {
        ST_RX,
        ST_DROP,
        ST_HDR,
        ST_PAY
`ifdef AXIS_FRAMER_CSUM_EN
        , ST_CSUM
`endif
    } state_t;

endpackage

// File: rtl/axis_framer_ram.sv
// Simple dual-port byte RAM: synchronous write, registered read.
module axis_framer_ram #(
    parameter int DEPTH = 2048,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] wr_addr,
    input  logic [7:0]    wr_data,
    input  logic [AW-1:0] rd_addr,
    output logic [7:0]    rd_data
);

    logic [7:0] mem [DEPTH];

    // NOTE: the array and read register carry no reset so this maps onto block RAM.
    always_ff @(posedge clk) begin
        if (we)
            mem[wr_addr] <= wr_data;
        rd_data <= mem[rd_addr];
    end

endmodule

// File: rtl/axis_pkt_framer.sv
// Store-and-forward framer: buffers one packet, re-emits it behind SOF/tid/length header.
// Defining AXIS_FRAMER_CSUM_EN appends an XOR checksum byte after the payload.
module axis_pkt_framer
    import axis_framer_pkg::*;
#(
    parameter int         DEPTH = 2048,
    parameter logic [7:0] SOF   = 8'hA5
) (
    input  logic             clki,
    input  logic             rstn,
    input  logic             s_axis_tvalid,
    output logic             s_axis_tready,
    input  logic [7:0]       s_axis_tdata,
    input  logic             s_axis_tlast,
    input  logic [1:0]       s_axis_tid,
    output logic             m_axis_tvalid,
    input  logic             m_axis_tready,
    output logic [7:0]       m_axis_tdata,
    output logic             m_axis_tlast,
    output logic [LEN_W-1:0] frame_cnt,
    output logic [LEN_W-1:0] drop_cnt
);

    localparam int               AW      = $clog2(DEPTH);
    localparam logic [LEN_W-1:0] DEPTH_L = LEN_W'(DEPTH);

    state_t           state;
    logic [LEN_W-1:0] len;
    logic [LEN_W-1:0] rd_ptr;
    logic [LEN_W-1:0] rd_ptr_nxt;
    logic [1:0]       tid_q;
    logic [1:0]       hdr_idx;
    logic             pay_last;
    logic [7:0]       rd_data;
    logic [7:0]       nxt_byte;
    logic             s_hs;
    logic             m_hs;
    logic             ram_we;
    logic             load_pay;
    logic             pay_is_last;
    logic             frame_done;

    assign s_hs        = s_axis_tvalid && s_axis_tready;
    assign m_hs        = m_axis_tvalid && m_axis_tready;
    assign ram_we      = (state == ST_RX) && s_hs && (len != DEPTH_L);
    assign pay_is_last = (rd_ptr == len - 1'b1);

`ifdef AXIS_FRAMER_CSUM_EN
    assign frame_done = m_hs && (state == ST_CSUM);
`else
    assign frame_done = m_hs && (state == ST_PAY) && pay_last;
`endif

    axis_framer_ram #(.DEPTH(DEPTH), .AW(AW)) u_ram (
        .clk     (clki),
        .we      (ram_we),
        .wr_addr (len[AW-1:0]),
        .wr_data (s_axis_tdata),
        .rd_addr (rd_ptr_nxt[AW-1:0]),
        .rd_data (rd_data)
    );

    // The RAM always reads the address the output will need next, so the
    // payload byte is waiting in rd_data when the header's last byte leaves.
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        load_pay   = 1'b0;
        nxt_byte   = rd_data;
        rd_ptr_nxt = rd_ptr;
        if (state == ST_HDR) begin
            case (hdr_idx)
                2'd0:    nxt_byte = {6'b0, tid_q};
                2'd1:    nxt_byte = len[LEN_W-1:8];
                2'd2:    nxt_byte = len[7:0];
                default: nxt_byte = rd_data;
            endcase
            load_pay = m_hs && (hdr_idx == 2'(HDR_LEN - 1));
        end else if (state == ST_PAY) begin
            load_pay = m_hs && !pay_last;
        end
        if (state == ST_RX)
            rd_ptr_nxt = '0;
        else if (load_pay)
            rd_ptr_nxt = rd_ptr + 1'b1;
    end

`ifdef AXIS_FRAMER_CSUM_EN
    logic [7:0] csum;

    always_ff @(posedge clki or negedge rstn) begin
        if (!rstn)
            csum <= '0;
        else if (state == ST_RX)
            csum <= '0;
        else if (m_hs && (state == ST_HDR || load_pay))
            csum <= csum ^ nxt_byte;
    end
`endif

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clki or negedge rstn) begin
        if (!rstn) begin
            state         <= ST_RX;
            len           <= '0;
            rd_ptr        <= '0;
            tid_q         <= '0;
            hdr_idx       <= '0;
            pay_last      <= 1'b0;
            s_axis_tready <= 1'b0;
            m_axis_tvalid <= 1'b0;
            m_axis_tdata  <= '0;
            m_axis_tlast  <= 1'b0;
            frame_cnt     <= '0;
            drop_cnt      <= '0;
        end else begin
            rd_ptr <= rd_ptr_nxt;
            case (state)
                ST_RX: begin
                    s_axis_tready <= 1'b1;
                    if (s_hs) begin
                        if (len == DEPTH_L) begin
                            // Overflow: a tlast here ends the packet on the spot.
                            if (s_axis_tlast) begin
                                drop_cnt <= drop_cnt + 1'b1;
                                len      <= '0;
                            end else begin
                                state <= ST_DROP;
                            end
                        end else begin
                            len <= len + 1'b1;
                            if (len == '0)
                                tid_q <= s_axis_tid;
                            if (s_axis_tlast) begin
                                state         <= ST_HDR;
                                s_axis_tready <= 1'b0;
                                m_axis_tvalid <= 1'b1;
                                m_axis_tdata  <= SOF;
                                m_axis_tlast  <= 1'b0;
                                hdr_idx       <= '0;
                            end
                        end
                    end
                end
                ST_DROP: begin
                    if (s_hs && s_axis_tlast) begin
                        drop_cnt <= drop_cnt + 1'b1;
                        len      <= '0;
                        state    <= ST_RX;
                    end
                end
                ST_HDR: begin
                    if (m_hs) begin
                        m_axis_tdata <= nxt_byte;
                        hdr_idx      <= hdr_idx + 1'b1;
                        if (load_pay) begin
                            state        <= ST_PAY;
                            pay_last     <= pay_is_last;
                            m_axis_tlast <= pay_is_last && !CSUM_ON;
                        end
                    end
                end
                ST_PAY: begin
                    if (load_pay) begin
                        m_axis_tdata <= nxt_byte;
                        pay_last     <= pay_is_last;
                        m_axis_tlast <= pay_is_last && !CSUM_ON;
                    end
`ifdef AXIS_FRAMER_CSUM_EN
                    else if (m_hs) begin
                        m_axis_tdata <= csum;
                        m_axis_tlast <= 1'b1;
                        state        <= ST_CSUM;
                    end
`endif
                end
                default: ;
            endcase
            if (frame_done) begin
                m_axis_tvalid <= 1'b0;
                m_axis_tlast  <= 1'b0;
                pay_last      <= 1'b0;
                frame_cnt     <= frame_cnt + 1'b1;
                len           <= '0;
                s_axis_tready <= 1'b1;
                state         <= ST_RX;
            end
        end
    end

endmodule

// File: tb/tb_axis_pkt_framer.sv
// Directed self-checking bench for axis_pkt_framer (DEPTH=16).
module tb_axis_pkt_framer;

    localparam int DEPTH = 16;

    logic        clki = 1'b0;
    logic        rstn = 1'b0;
    logic        s_axis_tvalid = 1'b0;
    logic        s_axis_tready;
    logic [7:0]  s_axis_tdata = '0;
    logic        s_axis_tlast = 1'b0;
    logic [1:0]  s_axis_tid = '0;
    logic        m_axis_tvalid;
    logic        m_axis_tready = 1'b0;
    logic [7:0]  m_axis_tdata;
    logic        m_axis_tlast;
    logic [15:0] frame_cnt;
    logic [15:0] drop_cnt;

    int tests = 0;
    int fails = 0;
    int exp_frames = 0;
    int exp_drops = 0;
    logic [7:0] tx_q[$];
    logic [7:0] exp_q[$];

    axis_pkt_framer #(.DEPTH(DEPTH), .SOF(8'hA5)) dut (
        .clki          (clki),
        .rstn          (rstn),
        .s_axis_tvalid (s_axis_tvalid),
        .s_axis_tready (s_axis_tready),
        .s_axis_tdata  (s_axis_tdata),
        .s_axis_tlast  (s_axis_tlast),
        .s_axis_tid    (s_axis_tid),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tready (m_axis_tready),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tlast  (m_axis_tlast),
        .frame_cnt     (frame_cnt),
        .drop_cnt      (drop_cnt)
    );

    always #5 clki = ~clki;

    initial begin
        #500us;
        $display("FAIL watchdog: simulation did not finish, observed timeout, required completion");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clki);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Expected frame: SOF, tid, big-endian length, payload, optional XOR checksum.
    task automatic build_exp(input logic [1:0] tid);
        logic [15:0] n;
`ifdef AXIS_FRAMER_CSUM_EN
        logic [7:0] x;
`endif
        n = 16'(tx_q.size());
        exp_q = {};
        exp_q.push_back(8'hA5);
        exp_q.push_back({6'b0, tid});
        exp_q.push_back(n[15:8]);
        exp_q.push_back(n[7:0]);
        foreach (tx_q[i]) exp_q.push_back(tx_q[i]);
`ifdef AXIS_FRAMER_CSUM_EN
        x = {6'b0, tid} ^ n[15:8] ^ n[7:0];
        foreach (tx_q[i]) x = x ^ tx_q[i];
        exp_q.push_back(x);
`endif
    endtask

    // Drives tx_q; tid is only valid on the first byte, later bytes carry a wrong tid.
    task automatic send_pkt(input logic [1:0] tid, input bit expect_frame, input string tag);
        int   i;
        int   cyc;
        logic hs;
        i   = 0;
        cyc = 0;
        while (i < tx_q.size() && cyc < 400) begin
            s_axis_tvalid = 1'b1;
            s_axis_tdata  = tx_q[i];
            s_axis_tlast  = (i == tx_q.size() - 1);
            s_axis_tid    = (i == 0) ? tid : ~tid;
            hs = s_axis_tready;
            step();
            cyc++;
            if (hs) i++;
        end
        s_axis_tvalid = 1'b0;
        s_axis_tlast  = 1'b0;
        check({tag, " all bytes accepted"}, i, tx_q.size());
        if (expect_frame) begin
            check({tag, " SOF valid next cycle"}, m_axis_tvalid, 1'b1);
            check({tag, " SOF byte"}, m_axis_tdata, 8'hA5);
            check({tag, " input stalled"}, s_axis_tready, 1'b0);
        end
    endtask

    // Collects one frame against exp_q with ready pattern pat (bit k%4 in cycle k).
    task automatic recv_frame(input logic [3:0] pat, input string tag);
        int         idx;
        int         cyc;
        int         first;
        bit         done;
        bit         stalled;
        logic       rdy_viol;
        logic [7:0] held_d;
        logic       held_l;
        idx = 0; cyc = 0; first = -1; done = 0; stalled = 0; rdy_viol = 1'b0;
        held_d = '0; held_l = 1'b0;
        while (!done && cyc < 400) begin
            m_axis_tready = pat[cyc % 4];
            if (stalled) begin
                check($sformatf("%s stall valid held b%0d", tag, idx), m_axis_tvalid, 1'b1);
                check($sformatf("%s stall data held b%0d", tag, idx), m_axis_tdata, held_d);
                check($sformatf("%s stall last held b%0d", tag, idx), m_axis_tlast, held_l);
            end
            if (m_axis_tvalid) begin
                if (first < 0) first = cyc;
                rdy_viol = rdy_viol | s_axis_tready;
            end
            if (m_axis_tvalid && m_axis_tready) begin
                check($sformatf("%s byte %0d", tag, idx), m_axis_tdata, exp_q[idx]);
                check($sformatf("%s tlast %0d", tag, idx), m_axis_tlast, (idx == exp_q.size() - 1));
                idx++;
                if (idx == exp_q.size()) done = 1;
            end
            stalled = m_axis_tvalid && !m_axis_tready;
            held_d  = m_axis_tdata;
            held_l  = m_axis_tlast;
            step();
            cyc++;
        end
        m_axis_tready = 1'b0;
        exp_frames++;
        check({tag, " frame complete"}, done, 1'b1);
        check({tag, " input ready low while emitting"}, rdy_viol, 1'b0);
        check({tag, " input ready back after last"}, s_axis_tready, 1'b1);
        check({tag, " frame_cnt"}, frame_cnt, 16'(exp_frames));
        if (pat == 4'hF)
            check({tag, " cycles without bubbles"}, cyc - first, exp_q.size());
    endtask

    initial begin
        int n;
        int cyc;
        bit seen;

        // Reset values
        step();
        step();
        check("rst s_tready", s_axis_tready, 1'b0);
        check("rst m_tvalid", m_axis_tvalid, 1'b0);
        check("rst m_tdata", m_axis_tdata, 8'h00);
        check("rst m_tlast", m_axis_tlast, 1'b0);
        check("rst frame_cnt", frame_cnt, 16'd0);
        check("rst drop_cnt", drop_cnt, 16'd0);
        rstn = 1'b1;
        #1;
        check("tready before first edge", s_axis_tready, 1'b0);
        step();
        check("tready after first edge", s_axis_tready, 1'b1);

        // Basic frame
        tx_q = '{8'h11, 8'h22, 8'h33};
        build_exp(2'd2);
        send_pkt(2'd2, 1'b1, "basic");
        recv_frame(4'hF, "basic");

        // Backpressure 1,0,0,1
        tx_q = '{8'h11, 8'h22, 8'h33};
        build_exp(2'd2);
        send_pkt(2'd2, 1'b1, "bp");
        recv_frame(4'b1001, "bp");

        // Overflow without tlast at the boundary
        tx_q = {};
        for (int i = 0; i < 20; i++) tx_q.push_back(8'(8'h40 + i));
        send_pkt(2'd1, 1'b0, "ovf");
        seen = 0;
        for (int i = 0; i < 8; i++) begin
            seen = seen | m_axis_tvalid;
            step();
        end
        exp_drops++;
        check("ovf no output", seen, 1'b0);
        check("ovf drop_cnt", drop_cnt, 16'(exp_drops));
        check("ovf input ready", s_axis_tready, 1'b1);

        tx_q = '{8'hAA, 8'hBB};
        build_exp(2'd0);
        send_pkt(2'd0, 1'b1, "post_ovf");
        recv_frame(4'hF, "post_ovf");

        // Exact fill
        tx_q = {};
        for (int i = 0; i < 16; i++) tx_q.push_back(8'(i));
        build_exp(2'd3);
        send_pkt(2'd3, 1'b1, "fill");
        recv_frame(4'hF, "fill");
        check("fill drop_cnt unchanged", drop_cnt, 16'(exp_drops));

        // Overflow where the 17th byte carries tlast
        tx_q = {};
        for (int i = 0; i < 17; i++) tx_q.push_back(8'(8'h80 + i));
        send_pkt(2'd1, 1'b0, "ovf17");
        step();
        exp_drops++;
        check("ovf17 drop_cnt", drop_cnt, 16'(exp_drops));
        check("ovf17 no output", m_axis_tvalid, 1'b0);

        // Back-to-back packets
        tx_q = '{8'h01, 8'h02};
        build_exp(2'd0);
        fork
            begin
                send_pkt(2'd0, 1'b1, "b2b1");
                tx_q = '{8'h03, 8'h04, 8'h05};
                send_pkt(2'd3, 1'b1, "b2b2");
            end
            begin
                recv_frame(4'hF, "b2b1");
                build_exp(2'd3);
                recv_frame(4'hF, "b2b2");
            end
        join

        // Reset during payload byte 2
        tx_q = '{8'h10, 8'h20, 8'h30, 8'h40, 8'h50};
        send_pkt(2'd1, 1'b1, "rstpay");
        m_axis_tready = 1'b1;
        n = 0;
        cyc = 0;
        while (n < 5 && cyc < 100) begin
            if (m_axis_tvalid) n++;
            step();
            cyc++;
        end
        check("rstpay reached byte 2", m_axis_tdata, 8'h20);
        rstn = 1'b0;
        #1;
        exp_frames = 0;
        exp_drops  = 0;
        check("rstpay s_tready", s_axis_tready, 1'b0);
        check("rstpay m_tvalid", m_axis_tvalid, 1'b0);
        check("rstpay m_tdata", m_axis_tdata, 8'h00);
        check("rstpay m_tlast", m_axis_tlast, 1'b0);
        check("rstpay frame_cnt", frame_cnt, 16'd0);
        check("rstpay drop_cnt", drop_cnt, 16'd0);
        m_axis_tready = 1'b0;
        step();
        rstn = 1'b1;
        step();
        check("rstpay tready back", s_axis_tready, 1'b1);
        check("rstpay no stale output", m_axis_tvalid, 1'b0);

        tx_q = '{8'h5A, 8'h6B, 8'h7C};
        build_exp(2'd2);
        send_pkt(2'd2, 1'b1, "after_rst");
        recv_frame(4'hF, "after_rst");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
